switch_mcast_scheduler: RTL and testbench

Output-side scheduler of the 4-port switch. It sits directly downstream of the per-port ingress FIFOs. It reads each FIFO head together with its 4-bit target mask and arbitrates every output port round-robin among the heads that want it. Multicast packets are replicated to all targeted outputs, and the head is popped only once every targeted output has taken a copy.

---
 rtl/switch_mcast_scheduler.sv | 115 +++++++++++
 tb/tb_switch_mcast_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_mcast_scheduler.sv
// Output-side scheduler for the 4-port switch: one replicate-and-pop FSM per input,
// one round-robin arbiter per output, multicast heads popped after their last copy.
module switch_mcast_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
  output logic [NUM_PORTS-1:0]          in_pop,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*2-1:0]        out_source,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [15:0]                   zero_tgt_drops
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_POP   = 2'd2;

  logic [1:0]           state   [NUM_PORTS];
  logic [NUM_PORTS-1:0] rem     [NUM_PORTS];
  logic [1:0]           ptr     [NUM_PORTS];
  logic [1:0]           winner  [NUM_PORTS];
  logic [NUM_PORTS-1:0] granted [NUM_PORTS];  // granted[i][j]: input i won output j
  logic [NUM_PORTS-1:0] win_any;
  logic [1:0]           cand;
  logic [2:0]           zero_cnt;
  logic [16:0]          drop_sum;

  // Per-output round-robin search starting at ptr[j]; an output busy with an
  // unaccepted word grants nobody.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    cand    = '0;
    win_any = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      granted[i] = '0;
      winner[i]  = '0;
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!out_valid[j] || out_ready[j]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          cand = ptr[j] + 2'(k);
          if (!win_any[j] && state[cand] == S_SERVE && rem[cand][j]) begin
            win_any[j]       = 1'b1;
            winner[j]        = cand;
            granted[cand][j] = 1'b1;
          end
        end
      end
    end
  end

  // Zero-mask heads from several inputs can land in the same cycle.
  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_pop[i] = (state[i] == S_POP);
      if (state[i] == S_IDLE && in_valid[i] && in_target[i*NUM_PORTS +: NUM_PORTS] == '0)
        zero_cnt = zero_cnt + 3'd1;
    end
    drop_sum = {1'b0, zero_tgt_drops} + 17'(zero_cnt);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_tgt_drops <= '0;
      out_valid      <= '0;
      out_data       <= '0;
      out_source     <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        state[i] <= S_IDLE;
        rem[i]   <= '0;
        ptr[i]   <= '0;
      end
    end else begin
      zero_tgt_drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      for (int i = 0; i < NUM_PORTS; i++) begin
        case (state[i])
          S_IDLE: begin
            if (in_valid[i]) begin
              rem[i]   <= in_target[i*NUM_PORTS +: NUM_PORTS];
              state[i] <= (in_target[i*NUM_PORTS +: NUM_PORTS] == '0) ? S_POP : S_SERVE;
            end
          end
          S_SERVE: begin
            rem[i] <= rem[i] & ~granted[i];
            if ((rem[i] & ~granted[i]) == '0)
              state[i] <= S_POP;
          end
          S_POP:   state[i] <= S_IDLE;
          default: state[i] <= S_IDLE;
        endcase
      end

      for (int j = 0; j < NUM_PORTS; j++) begin
        if (win_any[j]) begin
          out_valid[j]                   <= 1'b1;
          out_data[j*DATA_W +: DATA_W]   <= in_data[winner[j]*DATA_W +: DATA_W];
          out_source[j*2 +: 2]           <= winner[j];
          ptr[j]                         <= winner[j] + 2'd1;
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_mcast_scheduler.sv
// Randomised and directed bench for switch_mcast_scheduler; the bench plays the
// ingress FIFOs and checks every cycle against a transaction-level reference model.
module tb_switch_mcast_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [15:0] in_target;
  logic [3:0]  in_pop;
  logic [3:0]  out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_source;
  logic [3:0]  out_ready;
  logic [15:0] zero_tgt_drops;

  always #5 clk = ~clk;

  switch_mcast_scheduler #(.NUM_PORTS(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_target(in_target), .in_pop(in_pop),
    .out_valid(out_valid), .out_data(out_data), .out_source(out_source),
    .out_ready(out_ready), .zero_tgt_drops(zero_tgt_drops)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  tgt;
  } pkt_t;

  typedef enum int { WAIT, DELIVER, RELEASE } ph_t;

  pkt_t        fifo_q [4][$];
  ph_t         ph     [4];
  logic [3:0]  owed   [4];
  logic [3:0]  m_ov;
  logic [15:0] m_od   [4];
  int          m_os   [4];
  int          m_ptr  [4];
  int          m_drops;

  int          checks = 0;
  int          errors = 0;
  int          pops_seen [4];
  logic [3:0]  obs_pop, obs_ov;
  logic [63:0] obs_od;
  logic [7:0]  obs_os;
  logic [15:0] obs_drops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ph[i] = WAIT; owed[i] = '0; m_od[i] = '0; m_os[i] = 0; m_ptr[i] = 0;
    end
    m_ov    = '0;
    m_drops = 0;
  endtask

  task automatic push(input int i, input logic [15:0] d, input logic [3:0] t);
    pkt_t p;
    p.data = d;
    p.tgt  = t;
    fifo_q[i].push_back(p);
  endtask

  // One clock cycle: drive FIFO heads, compare at the falling edge, advance the model.
  task automatic step(input logic [3:0] rdy, input bit chk);
    logic [63:0] e_od;
    logic [7:0]  e_os;
    logic [3:0]  e_pop;
    ph_t         n_ph   [4];
    logic [3:0]  n_owed [4];
    logic [3:0]  n_ov;
    logic [15:0] n_od   [4];
    int          n_os   [4];
    int          n_ptr  [4];
    int          n_drops, win, best, d;
    bit          hold_rst;

    for (int i = 0; i < 4; i++) begin
      if (fifo_q[i].size() > 0) begin
        in_valid[i]          = 1'b1;
        in_data[i*16 +: 16]  = fifo_q[i][0].data;
        in_target[i*4 +: 4]  = fifo_q[i][0].tgt;
      end else begin
        in_valid[i]          = 1'b0;
        in_data[i*16 +: 16]  = '0;
        in_target[i*4 +: 4]  = '0;
      end
    end
    out_ready = rdy;

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e_pop[i]          = (ph[i] == RELEASE);
      e_od[i*16 +: 16]  = m_od[i];
      e_os[i*2 +: 2]    = 2'(m_os[i]);
    end
    obs_pop = in_pop; obs_ov = out_valid; obs_od = out_data;
    obs_os = out_source; obs_drops = zero_tgt_drops;
    if (chk) begin
      check("in_pop",     64'(obs_pop),   64'(e_pop));
      check("out_valid",  64'(obs_ov),    64'(m_ov));
      check("out_data",   obs_od,         e_od);
      check("out_source", 64'(obs_os),    64'(e_os));
      check("drops",      64'(obs_drops), 64'(m_drops));
    end
    for (int i = 0; i < 4; i++) pops_seen[i] += int'(obs_pop[i]);

    for (int i = 0; i < 4; i++) begin
      n_ph[i] = ph[i]; n_owed[i] = owed[i]; n_od[i] = m_od[i];
      n_os[i] = m_os[i]; n_ptr[i] = m_ptr[i];
    end
    n_ov    = m_ov;
    n_drops = m_drops;

    // Winner on each free output is the requester closest after the pointer.
    for (int j = 0; j < 4; j++) begin
      win  = -1;
      best = 4;
      if (!m_ov[j] || rdy[j]) begin
        for (int i = 0; i < 4; i++) begin
          if (ph[i] == DELIVER && owed[i][j]) begin
            d = (i - m_ptr[j] + 4) % 4;
            if (d < best) begin best = d; win = i; end
          end
        end
      end
      if (win >= 0) begin
        n_ov[j]         = 1'b1;
        n_od[j]         = fifo_q[win][0].data;
        n_os[j]         = win;
        n_ptr[j]        = (win + 1) % 4;
        n_owed[win][j]  = 1'b0;
      end else if (rdy[j]) begin
        n_ov[j] = 1'b0;
      end
    end

    for (int i = 0; i < 4; i++) begin
      case (ph[i])
        WAIT: if (fifo_q[i].size() > 0) begin
          n_owed[i] = fifo_q[i][0].tgt;
          if (fifo_q[i][0].tgt == 4'd0) begin
            n_ph[i] = RELEASE;
            if (n_drops < 65535) n_drops++;
          end else begin
            n_ph[i] = DELIVER;
          end
        end
        DELIVER: if (n_owed[i] == 4'd0) n_ph[i] = RELEASE;
        default: n_ph[i] = WAIT;
      endcase
    end
    hold_rst = rst;

    @(posedge clk);
    if (hold_rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (e_pop[i]) void'(fifo_q[i].pop_front());
        ph[i] = n_ph[i]; owed[i] = n_owed[i]; m_od[i] = n_od[i];
        m_os[i] = n_os[i]; m_ptr[i] = n_ptr[i];
      end
      m_ov    = n_ov;
      m_drops = n_drops;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pops_seen[i] = 0;
  endtask

  function automatic int queued();
    int n = 0;
    for (int i = 0; i < 4; i++) n += fifo_q[i].size();
    return n;
  endfunction

  initial begin
    int guard;
    logic [3:0] t;
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_target = '0; out_ready = '0;
    for (int i = 0; i < 4; i++) pops_seen[i] = 0;
    model_reset();
    step(4'hF, 1'b0);
    do_reset();

    // Unicast 0 -> 2.
    push(0, 16'hA5A5, 4'b0100);
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    check("uni_pop_c1", 64'(obs_pop[0]), 64'd0);
    step(4'hF, 1'b1);
    check("uni_valid", 64'(obs_ov[2]), 64'd1);
    check("uni_data",  64'(obs_od[47:32]), 64'hA5A5);
    check("uni_src",   64'(obs_os[5:4]), 64'd0);
    check("uni_pop_c2", 64'(obs_pop[0]), 64'd1);
    step(4'hF, 1'b1);
    check("uni_pop_c3", 64'(obs_pop[0]), 64'd0);

    // Multicast from input 1 to all outputs.
    do_reset();
    push(1, 16'h1234, 4'b1111);
    repeat (3) step(4'hF, 1'b1);
    check("mc_valid", 64'(obs_ov), 64'hF);
    check("mc_src",   64'(obs_os), 64'h55);
    repeat (2) step(4'hF, 1'b1);
    check("mc_pops",  64'(pops_seen[1]), 64'd1);

    // All inputs contend for output 0.
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 16'h0100 + 16'(i), 4'b0001);
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 1'b1);
      check("ct_src",  64'(obs_os[1:0]), 64'(k));
      check("ct_pop",  64'(obs_pop), 64'(4'b0001 << k));
      check("ct_data", 64'(obs_od[15:0]), 64'h0100 + 64'(k));
    end

    // Backpressure on output 3.
    do_reset();
    push(1, 16'hBEEF, 4'b1000);
    repeat (3) step(4'b0111, 1'b1);
    push(2, 16'hCAFE, 4'b1001);
    repeat (3) step(4'b0111, 1'b1);
    check("bp_out0_valid", 64'(obs_ov[0]), 64'd1);
    check("bp_out0_data",  64'(obs_od[15:0]), 64'hCAFE);
    check("bp_out0_src",   64'(obs_os[1:0]), 64'd2);
    check("bp_no_pop",     64'(obs_pop[2]), 64'd0);
    repeat (3) begin
      step(4'b0111, 1'b1);
      check("bp_held_pop", 64'(obs_pop[2]), 64'd0);
    end
    step(4'hF, 1'b1);
    check("bp_release_pop", 64'(obs_pop[2]), 64'd0);
    step(4'hF, 1'b1);
    check("bp_pop_after",  64'(obs_pop[2]), 64'd1);
    check("bp_out3_data",  64'(obs_od[63:48]), 64'hCAFE);
    check("bp_out3_src",   64'(obs_os[7:6]), 64'd2);

    // Zero-target head.
    do_reset();
    push(3, 16'h0000, 4'b0000);
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    check("zt_pop",   64'(obs_pop), 64'b1000);
    check("zt_valid", 64'(obs_ov), 64'd0);
    check("zt_drops", 64'(obs_drops), 64'd1);

    // Reset while input 0 is half served.
    do_reset();
    push(3, 16'h7777, 4'b0010);
    repeat (3) step(4'b1101, 1'b1);
    push(0, 16'h5A5A, 4'b0110);
    repeat (3) step(4'b1101, 1'b1);
    check("rs_partial", 64'(obs_ov[2:1]), 64'b11);
    check("rs_src2",    64'(obs_os[5:4]), 64'd0);
    rst = 1'b1;
    step(4'b1101, 1'b1);
    rst = 1'b0;
    step(4'hF, 1'b1);
    check("rs_cleared_valid", 64'(obs_ov), 64'd0);
    check("rs_cleared_pop",   64'(obs_pop), 64'd0);
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    check("rs_redeliver",  64'(obs_ov[2:1]), 64'b11);
    check("rs_resrc",      64'(obs_os[5:2]), 64'd0);
    check("rs_redata1",    64'(obs_od[31:16]), 64'h5A5A);
    check("rs_redata2",    64'(obs_od[47:32]), 64'h5A5A);
    check("rs_pop",        64'(obs_pop[0]), 64'd1);

    // Random traffic with random sink readiness.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(2) == 0 && fifo_q[i].size() < 3) begin
          t = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
          push(i, 16'($urandom), t);
        end
      end
      step(4'($urandom), 1'b1);
    end
    guard = 0;
    while (queued() > 0 && guard < 300) begin
      step(4'hF, 1'b1);
      guard++;
    end
    check("drain", 64'(queued()), 64'd0);
    repeat (4) step(4'hF, 1'b1);

    // Drop counter saturation: 0x10000 zero-target heads.
    do_reset();
    for (int n = 0; n < 16384; n++)
      for (int i = 0; i < 4; i++) push(i, 16'(n), 4'd0);
    guard = 0;
    while (queued() > 0 && guard < 40000) begin
      step(4'hF, 1'b1);
      guard++;
    end
    check("sat_drain", 64'(queued()), 64'd0);
    repeat (3) step(4'hF, 1'b1);
    check("drops_sat", 64'(obs_drops), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
